adc_pair_capture_packer: RTL
============================

// Module: adc_pair_capture_packer
// PURPOSE
//  Captures paired samples from the two ADC channels (A, B) after an arm/trigger sequence and
//  packs four sample pairs into each 128-bit word. Acts as the Avalon-MM write master that feeds
//  the 128-bit single-port on-chip sample memory (15-bit word address, 16 byte lanes, no waitrequest).
//  Sits between the ADC deserialisers and the sample RAM; the host reads results after done.
// PARAMETERS
//  ADC_W     12     sample width per channel (1..16), zero-extended to 16 bits in the packed word
//  ADDR_W    15     memory word-address width
//  DEPTH     18750  memory depth in 128-bit words; hard upper bound on words written
// PORTS
//  clk             in   1       system clock; all logic on rising edge
//  reset           in   1       synchronous, active-high reset
//  adc_a_data      in   ADC_W   channel A sample, qualified by adc_valid
//  adc_b_data      in   ADC_W   channel B sample, qualified by adc_valid
//  adc_valid       in   1       one-cycle strobe: A/B pair present this cycle
//  arm             in   1       pulse: IDLE/DONE -> ARMED, latches num_words
//  trigger         in   1       level: capture starts on first adc_valid with trigger=1 while ARMED
//  abort           in   1       pulse: terminate capture, flush partial word, go to DONE
//  num_words       in   ADDR_W  words to capture; 0 or >DEPTH is treated as DEPTH
//  mem_address     out  ADDR_W  word address to sample RAM
//  mem_writedata   out  128     packed data; pair k at bits [32k+31:32k], A low half, B high half
//  mem_byteenable  out  16      byte lanes valid for this write
//  mem_chipselect  out  1       equals mem_write
//  mem_write       out  1       one-cycle write strobe; RAM accepts every strobe (no backpressure)
//  mem_clken       out  1       tied high
//  busy            out  1       high in ARMED or CAPTURE
//  done            out  1       sticky high in DONE; cleared by arm or reset
//  words_written   out  ADDR_W  count of words written in current/last capture
// BEHAVIOUR
//  Reset: state=IDLE; mem_write, mem_chipselect, busy, done = 0; mem_address, words_written,
//   mem_writedata, mem_byteenable = 0; lane counter = 0; mem_clken = 1 always.
//  States: IDLE -arm-> ARMED -(adc_valid&trigger)-> CAPTURE -(last word written | abort)-> DONE
//   -arm-> ARMED. ARMED -abort-> DONE with no write. arm ignored in ARMED/CAPTURE.
//  Trigger sample: the pair with adc_valid&trigger in ARMED is pair 0 of word 0 (captured).
//  Packing: 2-bit lane counter; each adc_valid in CAPTURE stores {zext(B),zext(A)} into lane,
//   lane increments mod 4. On the 4th pair, the next cycle drives mem_write=1 for exactly one
//   cycle with the full word, byteenable=16'hFFFF, address=words_written (latency 1 cycle).
//   words_written increments in the same cycle as mem_write. Adjacent valids every cycle sustained.
//  Address starts at 0 per capture and never wraps; capture ends after the write of word
//   num_words-1 (effective) -> DONE on the cycle after that write strobe. adc_valid ignored in DONE/IDLE.
//  Abort in CAPTURE with lane counter L>0: next cycle one flush write of the partial word,
//   unused lanes zero, byteenable = (1<<(4*L))-1, counts as a word; then DONE. L=0: no write.
//  abort coincident with adc_valid: that pair is stored first, then flush uses updated L.
//  abort coincident with completing 4th pair: single full write only, then DONE.
//  abort and arm same cycle: abort wins. Reset mid-capture: immediate return to IDLE, no flush;
//   a write strobe pending in the reset cycle is dropped.
//  mem_writedata/byteenable hold last value when mem_write=0 (don't-care for RAM).
// TESTING
//  T1 arm, num_words=2, trigger=1, 8 valids A=n,B=0x100+n (n=0..7) -> writes addr0
//   {0x0103_0003,...,0x0100_0000}, addr1 pairs 4..7, byteenable FFFF, done=1, words_written=2.
//  T2 valids while ARMED with trigger=0 -> no writes; first valid with trigger=1 lands in lane 0.
//  T3 num_words=1, abort after 2 pairs -> one write addr0, byteenable 16'h00FF, lanes 2-3 zero, done.
//  T4 num_words=0 with continuous valids -> exactly 18750 writes, last address 18749, done, no wrap.
//  T5 reset asserted one cycle after 4th pair of word 3 -> no write at addr3, all outputs reset values.
//  T6 abort and arm in same cycle during CAPTURE at lane 0 -> no write, DONE, busy=0; re-arm restarts at addr0.

Source files
------------

// File: rtl/adc_pair_capture_packer.sv
// ADC A/B pair capture: arm/trigger sequencing and 4-pair packing
// into 128-bit words written to the on-chip sample RAM.
module adc_pair_capture_packer #(
    parameter int ADC_W  = 12,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 18750
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADC_W-1:0]  adc_a_data,
    input  logic [ADC_W-1:0]  adc_b_data,
    input  logic              adc_valid,
    input  logic              arm,
    input  logic              trigger,
    input  logic              abort,
    input  logic [ADDR_W-1:0] num_words,
    output logic [ADDR_W-1:0] mem_address,
    output logic [127:0]      mem_writedata,
    output logic [15:0]       mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_written
);

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPT,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        lane;
    logic [1:0]        lane_inc;
    logic [127:0]      acc;
    logic [127:0]      acc_nxt;
    logic [31:0]       pair;
    logic [ADDR_W-1:0] limit;
    logic [ADDR_W-1:0] ww_nxt;
    logic [ADDR_W-1:0] nw_eff;
    logic              wr_q;

    // Byte lanes covered by l filled pairs; l=0 stands for a full word.
    function automatic logic [15:0] lane_be(input logic [1:0] l);
        case (l)
            2'd1:    return 16'h000F;
            2'd2:    return 16'h00FF;
            2'd3:    return 16'h0FFF;
            default: return 16'hFFFF;
        endcase
    endfunction

    // The reset cycle suppresses a strobe that was already registered.
    assign mem_write      = wr_q & ~reset;
    assign mem_chipselect = wr_q & ~reset;
    assign mem_clken      = 1'b1;

    // Next packed word with the current pair inserted at the lane pointer.
    always_comb begin
        pair     = {16'(adc_b_data), 16'(adc_a_data)};
        acc_nxt  = acc;
        acc_nxt[{lane, 5'b0} +: 32] = pair;
        lane_inc = lane + 2'd1;
        ww_nxt   = words_written + 1'b1;
        nw_eff   = num_words;
        if (num_words == '0 || 32'(num_words) > 32'(DEPTH)) begin
            nw_eff = DEPTH_W;
        end
    end

    // Capture state machine, packing and write-master registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            lane           <= 2'd0;
            acc            <= '0;
            limit          <= '0;
            wr_q           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_address    <= '0;
            words_written  <= '0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
        end else begin
            wr_q <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (arm && !abort) begin
                        state         <= S_ARMED;
                        limit         <= nw_eff;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        lane          <= 2'd0;
                        acc           <= '0;
                        words_written <= '0;
                        mem_address   <= '0;
                    end
                end
                S_ARMED: begin
                    if (abort) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (adc_valid && trigger) begin
                        acc   <= acc_nxt;
                        lane  <= lane_inc;
                        state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (adc_valid) begin
                        if (lane == 2'd3 || abort) begin
                            wr_q           <= 1'b1;
                            mem_writedata  <= acc_nxt;
                            mem_byteenable <= lane_be(lane_inc);
                            mem_address    <= words_written;
                            words_written  <= ww_nxt;
                            acc            <= '0;
                            lane           <= 2'd0;
                            if (abort || ww_nxt == limit) begin
                                state <= S_STOP;
                            end
                        end else begin
                            acc  <= acc_nxt;
                            lane <= lane_inc;
                        end
                    end else if (abort) begin
                        if (lane != 2'd0) begin
                            wr_q           <= 1'b1;
                            mem_writedata  <= acc;
                            mem_byteenable <= lane_be(lane);
                            mem_address    <= words_written;
                            words_written  <= ww_nxt;
                            acc            <= '0;
                            lane           <= 2'd0;
                            state          <= S_STOP;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
